// File: rtl/mem_initiator.sv
// Requester-side master for the single-word RAM strobe/ready handshake.
// Holds one request in flight and answers with a one-cycle response pulse.
module mem_initiator #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic        busy,
    output logic [31:0] r_addr,
    output logic [31:0] w_addr,
    output logic [31:0] w_line,
    output logic        read,
    output logic        write,
    input  logic [31:0] r_line,
    input  logic        rrdy,
    input  logic        wrdy,
    input  logic        exc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] F_OK      = 2'd0;
    localparam logic [1:0] F_EXC     = 2'd1;
    localparam logic [1:0] F_TIMEOUT = 2'd2;

    state_t state;
    state_t state_nxt;

    logic [TW-1:0] cnt;
    logic [TW-1:0] cnt_nxt;

    logic        read_nxt;
    logic        write_nxt;
    logic [31:0] r_addr_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_line_nxt;
    logic        resp_valid_nxt;
    logic [31:0] resp_rdata_nxt;
    logic [1:0]  resp_fault_nxt;
    logic        busy_nxt;

    logic done;
    logic tmo;

    // The write strobe itself records the direction of the request in flight.
    assign done = write ? wrdy : rrdy;
    assign tmo  = (cnt == TW'(TIMEOUT - 1));

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done || exc || tmo) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        read_nxt       = read;
        write_nxt      = write;
        r_addr_nxt     = r_addr;
        w_addr_nxt     = w_addr;
        w_line_nxt     = w_line;
        resp_valid_nxt = 1'b0;
        resp_rdata_nxt = resp_rdata;
        resp_fault_nxt = resp_fault;
        cnt_nxt        = cnt;
        busy_nxt       = (state_nxt != IDLE);
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        w_addr_nxt = req_addr;
                        w_line_nxt = req_wdata;
                        write_nxt  = 1'b1;
                        read_nxt   = 1'b0;
                    end else begin
                        r_addr_nxt = req_addr;
                        read_nxt   = 1'b1;
                        write_nxt  = 1'b0;
                    end
                end
            end
            ISSUE: begin
                // exc may still be left over from an earlier fault here.
                cnt_nxt = '0;
            end
            WAIT: begin
                if (done) begin
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = write ? 32'd0 : r_line;
                    resp_fault_nxt = F_OK;
                end else if (exc) begin
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = 32'd0;
                    resp_fault_nxt = F_EXC;
                end else if (tmo) begin
                    read_nxt       = 1'b0;
                    write_nxt      = 1'b0;
                    resp_valid_nxt = 1'b1;
                    resp_rdata_nxt = 32'd0;
                    resp_fault_nxt = F_TIMEOUT;
                end else begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            RESP: begin
                resp_valid_nxt = 1'b0;
            end
            default: begin
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read       <= 1'b0;
            write      <= 1'b0;
            r_addr     <= 32'd0;
            w_addr     <= 32'd0;
            w_line     <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= F_OK;
            busy       <= 1'b0;
            cnt        <= '0;
        end else begin
            read       <= read_nxt;
            write      <= write_nxt;
            r_addr     <= r_addr_nxt;
            w_addr     <= w_addr_nxt;
            w_line     <= w_line_nxt;
            resp_valid <= resp_valid_nxt;
            resp_rdata <= resp_rdata_nxt;
            resp_fault <= resp_fault_nxt;
            busy       <= busy_nxt;
            cnt        <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: directed vector table, handshake corner cases
// and randomized traffic against a word-level RAM reference model.
module tb_mem_initiator;

    localparam int TIMEOUT = 16;
    localparam int TW      = 5;
    localparam int RAMSZ   = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;
    logic        busy;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
    logic [31:0] w_line;
    logic        read;
    logic        write;
    logic [31:0] r_line;
    logic        rrdy;
    logic        wrdy;
    logic        exc;

    mem_initiator #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .busy       (busy),
        .r_addr     (r_addr),
        .w_addr     (w_addr),
        .w_line     (w_line),
        .read       (read),
        .write      (write),
        .r_line     (r_line),
        .rrdy       (rrdy),
        .wrdy       (wrdy),
        .exc        (exc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return {16'hA5A5, 16'(i)};
    endfunction

    // RAM model: answers lat edges after it first sees a strobe, once per strobe.
    logic [31:0] ram_mem [RAMSZ];
    int          ram_lat  = 0;
    bit          ram_mute = 1'b0;
    int          ram_wcnt;
    bit          ram_done;
    bit          ram_loaded = 1'b0;

    always @(posedge clk) begin
        rrdy <= 1'b0;
        wrdy <= 1'b0;
        if (!ram_loaded) begin
            for (int i = 0; i < RAMSZ; i++) ram_mem[i] <= init_word(i);
            ram_loaded <= 1'b1;
            exc        <= 1'b0;
            r_line     <= 32'd0;
            ram_done   <= 1'b0;
            ram_wcnt   <= 0;
        end else if (!(read || write)) begin
            ram_done <= 1'b0;
            ram_wcnt <= 0;
        end else if (!ram_done && !ram_mute) begin
            if (ram_wcnt >= ram_lat) begin
                ram_done <= 1'b1;
                if (read) begin
                    if (r_addr < RAMSZ) begin
                        r_line <= ram_mem[r_addr[9:0]];
                        rrdy   <= 1'b1;
                        exc    <= 1'b0;
                    end else begin
                        exc <= 1'b1;
                    end
                end else begin
                    if (w_addr < RAMSZ) begin
                        ram_mem[w_addr[9:0]] <= w_line;
                        wrdy <= 1'b1;
                        exc  <= 1'b0;
                    end else begin
                        exc <= 1'b1;
                    end
                end
            end else begin
                ram_wcnt <= ram_wcnt + 1;
            end
        end
    end

    // Strobe monitor: high-cycle count, rising edges, and RAM-side field errors.
    logic [31:0] cur_addr  = 32'd0;
    logic [31:0] cur_wdata = 32'd0;
    int hi_cnt   = 0;
    int rise_cnt = 0;
    int mon_bad  = 0;
    bit prev_stb = 1'b0;

    always @(negedge clk) begin
        hi_cnt   <= hi_cnt + int'(read || write);
        rise_cnt <= rise_cnt + int'((read || write) && !prev_stb);
        prev_stb <= read || write;
        mon_bad  <= mon_bad + int'(read && write)
                  + int'(read && (r_addr != cur_addr))
                  + int'(write && ((w_addr != cur_addr) || (w_line != cur_wdata)));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    logic [31:0] ref_mem [RAMSZ];

    task automatic run_txn(input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat,
                           input bit mute, input logic [1:0] efault,
                           input logic [31:0] erdata, input string tag);
        int k;
        int h0;
        int r0;
        int b0;
        int elat;
        elat = mute ? TIMEOUT + 2 : 3 + lat;
        @(negedge clk);
        ram_lat   = lat;
        ram_mute  = mute;
        cur_addr  = addr;
        cur_wdata = wdata;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        h0 = hi_cnt;
        r0 = rise_cnt;
        b0 = mon_bad;
        k  = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) req_valid = 1'b0;
        end while (!resp_valid && k < 60);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " latency"}, 32'(k), 32'(elat));
        chk({tag, " fault"}, 32'(resp_fault), 32'(efault));
        chk({tag, " rdata"}, resp_rdata, erdata);
        chk({tag, " strobe cycles"}, 32'(hi_cnt - h0), 32'(elat - 1));
        chk({tag, " strobe rises"}, 32'(rise_cnt - r0), 32'd1);
        chk({tag, " ram fields"}, 32'(mon_bad - b0), 32'd0);
        chk({tag, " busy in resp"}, {busy, req_ready}, 32'b10);
        @(negedge clk);
        chk({tag, " after resp"}, {resp_valid, req_ready, busy}, 32'b010);
        chk({tag, " fault hold"}, {resp_fault, resp_rdata[29:0]},
            {efault, erdata[29:0]});
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          mute;
        logic [1:0]  fault;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int k;
        int r0;
        int rb;
        int pulses;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          mute;
        logic [1:0]  ef;
        logic [31:0] er;

        tbl[0]  = '{1'b0, 32'd5,    32'd0,          0, 1'b0, 2'd0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 32'd7,    32'h12345678,   0, 1'b0, 2'd0, 32'd0};
        tbl[2]  = '{1'b0, 32'd7,    32'd0,          0, 1'b0, 2'd0, 32'h12345678};
        tbl[3]  = '{1'b0, 32'd2000, 32'd0,          0, 1'b0, 2'd1, 32'd0};
        tbl[4]  = '{1'b0, 32'd5,    32'd0,          0, 1'b0, 2'd0, 32'hDEADBEEF};
        tbl[5]  = '{1'b0, 32'd9,    32'd0,          0, 1'b1, 2'd2, 32'd0};
        tbl[6]  = '{1'b0, 32'd9,    32'd0,          0, 1'b0, 2'd0, init_word(9)};
        tbl[7]  = '{1'b1, 32'd3000, 32'h0BADF00D,   2, 1'b0, 2'd1, 32'd0};
        tbl[8]  = '{1'b1, 32'd8,    32'hCAFEF00D,   0, 1'b0, 2'd0, 32'd0};
        tbl[9]  = '{1'b0, 32'd8,    32'd0,          3, 1'b0, 2'd0, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 32'd1023, 32'h5A5A1023,   1, 1'b0, 2'd0, 32'd0};
        tbl[11] = '{1'b0, 32'd1023, 32'd0,          0, 1'b0, 2'd0, 32'h5A5A1023};
        tbl[12] = '{1'b0, 32'd1024, 32'd0,          1, 1'b0, 2'd1, 32'd0};
        tbl[13] = '{1'b0, 32'd0,    32'd0,          0, 1'b0, 2'd0, init_word(0)};
        tbl[14] = '{1'b1, 32'd8,    32'h77777777,   0, 1'b1, 2'd2, 32'd0};
        tbl[15] = '{1'b0, 32'd8,    32'd0,          1, 1'b0, 2'd0, 32'hCAFEF00D};

        for (int i = 0; i < RAMSZ; i++) ref_mem[i] = init_word(i);

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        #1;
        chk("reset ctl", {req_ready, busy, read, write, resp_valid}, 32'b10000);
        chk("reset resp", {resp_fault, resp_rdata[29:0]}, 32'd0);
        chk("reset addr", r_addr | w_addr | w_line, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].lat,
                    tbl[i].mute, tbl[i].fault, tbl[i].rdata,
                    $sformatf("vec%0d", i));
            if (tbl[i].we && tbl[i].fault == 2'd0)
                ref_mem[tbl[i].addr[9:0]] = tbl[i].wdata;
        end

        // Back-to-back reads with req_valid held high throughout.
        @(negedge clk);
        ram_lat   = 0;
        ram_mute  = 1'b0;
        cur_addr  = 32'd5;
        req_we    = 1'b0;
        req_addr  = 32'd5;
        req_valid = 1'b1;
        r0 = rise_cnt;
        rb = 0;
        k  = 0;
        do begin
            @(negedge clk);
            k++;
            if (req_ready) rb++;
        end while (!resp_valid && k < 60);
        chk("b2b ready low", 32'(rb), 32'd0);
        chk("b2b first data", resp_rdata, ref_mem[5]);
        cur_addr = 32'd7;
        req_addr = 32'd7;
        @(negedge clk);
        chk("b2b idle gap", {req_ready, read, busy}, 32'b100);
        @(negedge clk);
        chk("b2b second accept", {read, busy, r_addr}, {2'b11, 32'd7});
        req_valid = 1'b0;
        k = 1;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 60);
        chk("b2b second latency", 32'(k), 32'd3);
        chk("b2b second data", resp_rdata, ref_mem[7]);
        chk("b2b rises", 32'(rise_cnt - r0), 32'd2);
        @(negedge clk);

        // Randomized traffic against the word-level reference.
        for (int t = 0; t < 50; t++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(1024, 70000))
                                                : 32'($urandom_range(0, 63));
            wdata = $urandom;
            lat   = exc ? 0 : int'($urandom_range(0, 3));
            mute  = !exc && ($urandom_range(0, 7) == 0);
            if (mute) begin
                ef = 2'd2;
                er = 32'd0;
            end else if (addr >= RAMSZ) begin
                ef = 2'd1;
                er = 32'd0;
            end else begin
                ef = 2'd0;
                er = we ? 32'd0 : ref_mem[addr[9:0]];
                if (we) ref_mem[addr[9:0]] = wdata;
            end
            run_txn(we, addr, wdata, lat, mute, ef, er, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Asynchronous reset while a read waits on a silent RAM.
        @(negedge clk);
        ram_mute  = 1'b1;
        cur_addr  = 32'd4;
        req_we    = 1'b0;
        req_addr  = 32'd4;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst pre wait", {read, busy, req_ready}, 32'b110);
        #2;
        rst = 1'b1;
        #1;
        chk("rst async", {read, busy, req_ready, resp_valid}, 32'b0010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        ram_mute = 1'b0;
        pulses   = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        chk("rst no resp", 32'(pulses), 32'd0);
        run_txn(1'b0, 32'd4, 32'd0, 0, 1'b0, 2'd0, ref_mem[4], "post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no summary, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
